// File: rtl/hazard_ctrl_if.sv
// Pipeline hazard bus: hazard-relevant fields of the FD/DX/X stages flowing
// into the sequencing controller, and the latch enables and bubble/flush
// selects flowing back out to the datapath.
interface hazard_ctrl_if;
  logic [4:0]  fd_regA;
  logic [4:0]  fd_regB;
  logic        fd_uses_regB;
  logic [4:0]  dx_rd;
  logic        dx_is_load;
  logic        dx_is_multdiv;
  logic        multdiv_ready;
  logic        branch_taken;

  logic        pc_wren;
  logic        fd_wren;
  logic        dx_wren;
  logic        xm_wren;
  logic        fd_flush;
  logic        dx_bubble;
  logic        xm_bubble;
  logic        multdiv_start;
  logic        md_timeout;
  logic [15:0] stall_cycles;

  // Datapath side: reports stage contents, consumes the control selects.
  modport master (
    output fd_regA, fd_regB, fd_uses_regB, dx_rd, dx_is_load,
           dx_is_multdiv, multdiv_ready, branch_taken,
    input  pc_wren, fd_wren, dx_wren, xm_wren, fd_flush, dx_bubble,
           xm_bubble, multdiv_start, md_timeout, stall_cycles
  );

  // Controller side.
  modport slave (
    input  fd_regA, fd_regB, fd_uses_regB, dx_rd, dx_is_load,
           dx_is_multdiv, multdiv_ready, branch_taken,
    output pc_wren, fd_wren, dx_wren, xm_wren, fd_flush, dx_bubble,
           xm_bubble, multdiv_start, md_timeout, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Sequencing controller for the 5-stage core. Handles load-use stalls,
// multi-cycle multdiv freezes with a timeout escape, and squashing of the
// wrong-path instructions behind a taken branch. Also keeps a saturating
// count of cycles in which the PC was held.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic         clock,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt, next_cnt;
  logic [15:0]      stall_cnt;

  logic pc_wren, fd_wren, dx_wren, xm_wren;
  logic fd_flush, dx_bubble, xm_bubble;
  logic multdiv_start, md_timeout;
  logic load_use;

  // Register 0 is hard-wired, so a load targeting it can never be a real producer.
  assign load_use = bus.dx_is_load && (bus.dx_rd != 5'd0) &&
                    ((bus.dx_rd == bus.fd_regA) ||
                     (bus.fd_uses_regB && (bus.dx_rd == bus.fd_regB)));

  // State register, multdiv wait counter and saturating stall counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      if (!pc_wren && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

  // Next-state and control selects; reset forces the idle set.
  always_comb begin
    next_state    = state;
    next_cnt      = wait_cnt;
    pc_wren       = 1'b1;
    fd_wren       = 1'b1;
    dx_wren       = 1'b1;
    xm_wren       = 1'b1;
    fd_flush      = 1'b0;
    dx_bubble     = 1'b0;
    xm_bubble     = 1'b0;
    multdiv_start = 1'b0;
    md_timeout    = 1'b0;

    if (!reset) begin
      case (state)
        RUN: begin
          if (bus.branch_taken) begin
            // FD holds a wrong-path instruction, so any hazard it raises is moot.
            fd_flush  = 1'b1;
            dx_bubble = 1'b1;
          end else if (bus.dx_is_multdiv) begin
            multdiv_start = 1'b1;
            pc_wren       = 1'b0;
            fd_wren       = 1'b0;
            dx_wren       = 1'b0;
            xm_bubble     = 1'b1;
            next_state    = MD_WAIT;
            next_cnt      = '0;
          end else if (load_use) begin
            // Next cycle DX holds the nop, so the hazard clears by itself.
            pc_wren   = 1'b0;
            fd_wren   = 1'b0;
            dx_bubble = 1'b1;
          end
        end

        MD_WAIT: begin
          pc_wren   = 1'b0;
          fd_wren   = 1'b0;
          dx_wren   = 1'b0;
          xm_bubble = 1'b1;
          if (bus.multdiv_ready) begin
            next_state = MD_DONE;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            md_timeout = 1'b1;
            next_state = MD_DONE;
          end else begin
            next_cnt = wait_cnt + CNT_W'(1);
          end
        end

        MD_DONE: begin
          // Handoff cycle: the multdiv instruction and result move into XM.
          next_state = RUN;
        end

        default: next_state = RUN;
      endcase
    end
  end

  assign bus.pc_wren       = pc_wren;
  assign bus.fd_wren       = fd_wren;
  assign bus.dx_wren       = dx_wren;
  assign bus.xm_wren       = xm_wren;
  assign bus.fd_flush      = fd_flush;
  assign bus.dx_bubble     = dx_bubble;
  assign bus.xm_bubble     = xm_bubble;
  assign bus.multdiv_start = multdiv_start;
  assign bus.md_timeout    = md_timeout;
  assign bus.stall_cycles  = stall_cnt;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core.
- Drives the write enables of the PC, FD, DX and XM latches, plus bubble/flush selects.
- Resolves three hazards:
  - load-use hazards (stall plus bubble),
  - multi-cycle multdiv execution (freeze the front end, then hand off),
  - taken branches resolved in X (squash the wrong-path instructions).
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MD_TIMEOUT, 40, maximum number of MD_WAIT cycles before a forced abort.
- CNT_W, 6, width of the multdiv wait counter; must satisfy 2^CNT_W > MD_TIMEOUT.

Ports:
- clock  in  1  single system clock, all state on the rising edge.
- reset  in  1  synchronous, active-high.
- fd_regA  in  5  source register A of the instruction in FD.
- fd_regB  in  5  source register B of the instruction in FD.
- fd_uses_regB  in  1  FD instruction actually reads regB.
- dx_rd  in  5  destination register of the instruction in DX.
- dx_is_load  in  1  DX instruction is lw.
- dx_is_multdiv  in  1  DX instruction is mul or div; it is now in X.
- multdiv_ready  in  1  multdiv unit result is valid this cycle.
- branch_taken  in  1  X-stage instruction redirects the PC this cycle.
- pc_wren  out  1  PC register enable.
- fd_wren  out  1  FD latch enable.
- dx_wren  out  1  DX latch enable.
- xm_wren  out  1  XM latch enable.
- fd_flush  out  1  FD loads a nop instead of the fetched instruction.
- dx_bubble  out  1  DX loads zero control signals (nop).
- xm_bubble  out  1  XM loads zero control signals (nop).
- multdiv_start  out  1  single-cycle start pulse to the multdiv unit.
- md_timeout  out  1  single-cycle pulse when a multdiv aborts on timeout.
- stall_cycles  out  16  saturating count of cycles with pc_wren=0.

Behaviour:
- All outputs are combinational from the registered state and the current inputs. The state, wait counter and stall_cycles are registered.
- While reset=1, outputs are forced to the idle set:
  - all wren=1;
  - fd_flush, dx_bubble, xm_bubble, multdiv_start, md_timeout all =0.
- On the reset edge: state<=RUN, wait counter<=0, stall_cycles<=0. Reset mid-multdiv abandons the operation and raises no start and no timeout pulse.
- The idle set is all wren=1 with every flush/bubble/pulse output =0.
- State RUN, evaluated in priority order (highest first):
  1. branch_taken=1: idle set except fd_flush=1 and dx_bubble=1. Stay in RUN. This overrides load-use because the FD instruction is on the wrong path.
  2. dx_is_multdiv=1: multdiv_start=1; pc_wren=fd_wren=dx_wren=0; xm_bubble=1. Next state MD_WAIT, counter<=0.
  3. Load-use: dx_is_load=1 and dx_rd!=0 and (dx_rd==fd_regA, or fd_uses_regB=1 and dx_rd==fd_regB):
     - pc_wren=fd_wren=0, dx_bubble=1, xm_wren=1;
     - exactly one bubble per hazard, because the next cycle DX holds a nop;
     - stay in RUN.
  4. Otherwise: idle set.
- State MD_WAIT:
  - pc_wren=fd_wren=dx_wren=0, xm_bubble=1; branch_taken is ignored.
  - multdiv_ready=1 goes to MD_DONE. The result handoff happens in MD_DONE, not in this cycle.
  - Otherwise, if the counter equals MD_TIMEOUT-1: md_timeout=1 and next state MD_DONE.
  - Otherwise the counter increments.
- State MD_DONE, lasting exactly one cycle:
  - idle set (the result and the multdiv instruction enter XM), then RUN;
  - dx_is_multdiv is not re-evaluated this cycle, so there is no restart;
  - a back-to-back multdiv now in DX starts in the following RUN cycle.
- multdiv_start is asserted only on the RUN→MD_WAIT transition cycle.
- stall_cycles increments on every non-reset cycle with pc_wren=0, and saturates at 0xFFFF.
- Register 0 never causes a stall. dx_rd==0 with a match produces no bubble.

Test Plan:
- Load-use on regA:
  - Stimulus: dx_is_load=1, dx_rd=5, fd_regA=5.
  - Response: one cycle with pc_wren=fd_wren=0 and dx_bubble=1.
  - Next cycle (dx_is_load=0): idle set; stall_cycles=1.
- Load on regB ignored when unused:
  - Stimulus: dx_rd=7, fd_regB=7, fd_uses_regB=0.
  - Response: no stall.
  - Stimulus: dx_rd=0, fd_regA=0.
  - Response: no stall.
- Multdiv handoff:
  - Stimulus: dx_is_multdiv=1, then multdiv_ready=1 on the 10th MD_WAIT cycle.
  - Response: multdiv_start pulses once.
  - Response: 10 cycles with wren=0 and xm_bubble=1, then one MD_DONE cycle with the idle set, then RUN.
  - Response: stall_cycles=11.
- Multdiv timeout:
  - Stimulus: dx_is_multdiv=1 and ready never asserted, MD_TIMEOUT=40.
  - Response: md_timeout pulses on the 40th MD_WAIT cycle, followed by one MD_DONE cycle.
- Branch priority:
  - Stimulus: branch_taken=1 at the same time as a load-use match.
  - Response: fd_flush=1, dx_bubble=1, all wren=1.
  - Stimulus: branch_taken=1 during MD_WAIT.
  - Response: ignored.
- Reset and counter saturation:
  - Stimulus: reset asserted on the 3rd MD_WAIT cycle.
  - Response: idle set, state RUN, stall_cycles=0, no pulses.
  - Stimulus: preload the counter via 65,540 forced stall cycles.
  - Response: stall_cycles=0xFFFF.
